// File: rtl/gshare_pht.sv
// Gshare pattern history table of 2-bit saturating counters.
// Registered lookup, single-cycle train, init sweep after reset.
module gshare_pht #(
   parameter int GHR_WIDTH  = 5,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  ready,
   input  logic                  lookup_en,
   input  logic [31:0]           lookup_pc,
   input  logic [GHR_WIDTH-1:0]  ghr_in,
   output logic                  pred_valid,
   output logic                  pred_taken,
   output logic [ADDR_WIDTH-1:0] pred_index,
   input  logic                  update_en,
   input  logic [ADDR_WIDTH-1:0] update_index,
   input  logic                  update_taken
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [ADDR_WIDTH-1:0] ptr_q;
   logic [1:0]            pht [DEPTH];
   logic [ADDR_WIDTH-1:0] hist;
   logic [ADDR_WIDTH-1:0] idx;
   logic [1:0]            upd_cur;
   logic [1:0]            upd_nxt;
   logic                  rd_taken;
   logic                  run;
   logic                  unused_pc;

   generate
      if (GHR_WIDTH < ADDR_WIDTH) begin : g_ext
         assign hist = {{(ADDR_WIDTH-GHR_WIDTH){1'b0}}, ghr_in};
      end else begin : g_trunc
         assign hist = ghr_in[ADDR_WIDTH-1:0];
         if (GHR_WIDTH > ADDR_WIDTH) begin : g_drop
            logic unused_hist;
            assign unused_hist = ^ghr_in[GHR_WIDTH-1:ADDR_WIDTH];
         end
      end
   endgenerate

   assign unused_pc = ^{lookup_pc[31:ADDR_WIDTH+2], lookup_pc[1:0]};
   assign idx       = lookup_pc[ADDR_WIDTH+1:2] ^ hist;
   assign run       = (state_q == RUN);
   assign ready     = run;
   assign upd_cur   = pht[update_index];

   // Saturating train value for the entry being updated
   always_comb begin
      upd_nxt = upd_cur;
      if (update_taken) begin
         if (upd_cur != 2'd3) upd_nxt = upd_cur + 2'd1;
      end else begin
         if (upd_cur != 2'd0) upd_nxt = upd_cur - 2'd1;
      end
   end

   // Read with write-first bypass when the update hits the looked-up entry
   always_comb begin
      rd_taken = pht[idx][1];
      if (update_en && update_index == idx) rd_taken = upd_nxt[1];
   end

   // Next state: leave INIT once the last entry is written
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         INIT: if (ptr_q == '1) state_d = RUN;
         RUN:  state_d = RUN;
         default: state_d = INIT;
      endcase
   end

   // State register and sweep pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == INIT) ptr_q <= ptr_q + 1'b1;
      end
   end

   // Table writes: sweep in INIT, training in RUN
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_q == INIT) begin
            pht[ptr_q] <= 2'b01;
         end else if (update_en) begin
            pht[update_index] <= upd_nxt;
         end
      end
   end

   // Registered prediction; taken/index hold when no lookup is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
         pred_index <= '0;
      end else begin
         pred_valid <= run & lookup_en;
         if (run && lookup_en) begin
            pred_index <= idx;
            pred_taken <= rd_taken;
         end
      end
   end

endmodule

// File: tb/tb_gshare_pht.sv
// Bench for gshare_pht: directed steps plus random traffic
// against a table-of-integers reference model.
module tb_gshare_pht;

   localparam int GW = 5;
   localparam int AW = 6;
   localparam int N  = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          ready;
   logic          lookup_en;
   logic [31:0]   lookup_pc;
   logic [GW-1:0] ghr_in;
   logic          pred_valid;
   logic          pred_taken;
   logic [AW-1:0] pred_index;
   logic          update_en;
   logic [AW-1:0] update_index;
   logic          update_taken;

   int vectors     = 0;
   int miscompares = 0;

   int model [N];
   int since = 0;
   bit e_pv  = 0;
   bit e_pt  = 0;
   int e_pi  = 0;

   gshare_pht #(.GHR_WIDTH(GW), .ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .rst         (rst),
      .ready       (ready),
      .lookup_en   (lookup_en),
      .lookup_pc   (lookup_pc),
      .ghr_in      (ghr_in),
      .pred_valid  (pred_valid),
      .pred_taken  (pred_taken),
      .pred_index  (pred_index),
      .update_en   (update_en),
      .update_index(update_index),
      .update_taken(update_taken)
   );

   always #5 clk = ~clk;

   function automatic int hash(longint unsigned pc, int unsigned g);
      return int'((pc / 4) % N) ^ int'(g % N);
   endfunction

   function automatic int train(int c, bit t);
      if (t) return (c == 3) ? 3 : c + 1;
      return (c == 0) ? 0 : c - 1;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(bit r, bit le, logic [31:0] pc, logic [GW-1:0] g,
                      bit ue, int ui, bit ut);
      int idx;
      int c;
      rst          = r;
      lookup_en    = le;
      lookup_pc    = pc;
      ghr_in       = g;
      update_en    = ue;
      update_index = ui[AW-1:0];
      update_taken = ut;
      @(posedge clk);
      #1;
      if (r) begin
         since = 0;
         e_pv  = 0;
         e_pt  = 0;
         e_pi  = 0;
      end else if (since < N) begin
         since++;
         e_pv = 0;
         if (since == N) foreach (model[i]) model[i] = 1;
      end else begin
         idx = hash(longint'(pc), int'(g));
         c   = model[idx];
         if (ue && ui == idx) c = train(c, ut);
         e_pv = le;
         if (le) begin
            e_pi = idx;
            e_pt = (c >= 2);
         end
         if (ue) model[ui] = train(model[ui], ut);
      end
      chk("ready", ready, since >= N);
      chk("pred_valid", pred_valid, e_pv);
      chk("pred_index", pred_index, e_pi);
      chk("pred_taken", pred_taken, e_pt);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic look(int i);
      cyc(0, 1, 32'(i * 4), 0, 0, 0, 0);
   endtask

   task automatic upd(int i, bit t);
      cyc(0, 0, 0, 0, 1, i, t);
   endtask

   initial begin
      bit            r;
      bit            le;
      bit            ue;
      bit            ut;
      logic [31:0]   pc;
      logic [GW-1:0] g;
      int            ui;

      // 1: reset, 64 cycles not ready, first lookup not taken
      cyc(1, 0, 0, 0, 0, 0, 0);
      chk("t1_ready_rst", ready, 1'b0);
      idle(63);
      chk("t1_ready_63", ready, 1'b0);
      idle(1);
      chk("t1_ready_64", ready, 1'b1);
      cyc(0, 1, 32'h1234_5678, 5'h0b, 0, 0, 0);
      chk("t1_valid", pred_valid, 1'b1);
      chk("t1_taken", pred_taken, 1'b0);

      // 2: index hash
      cyc(0, 1, 32'h0000_0040, 5'b00011, 0, 0, 0);
      chk("t2_idx13", pred_index, 6'h13);
      cyc(0, 1, 32'h0000_0040, 5'b10000, 0, 0, 0);
      chk("t2_idx00", pred_index, 6'h00);
      idle(1);
      chk("t2_hold", pred_index, 6'h00);

      // 3: saturation on entry 5
      repeat (3) upd(5, 1);
      look(5);
      chk("t3_sat3", pred_taken, 1'b1);
      upd(5, 1);
      upd(5, 0);
      look(5);
      chk("t3_two", pred_taken, 1'b1);
      upd(5, 0);
      upd(5, 0);
      look(5);
      chk("t3_zero", pred_taken, 1'b0);
      upd(5, 0);
      upd(5, 1);
      look(5);
      chk("t3_floor", pred_taken, 1'b0);

      // 4: write-first bypass on entry 9
      cyc(0, 1, 32'(9 * 4), 0, 1, 9, 1);
      chk("t4_bypass", pred_taken, 1'b1);
      look(9);
      chk("t4_after", pred_taken, 1'b1);

      // 5: train 5 to 3, reset with a lookup in flight
      repeat (3) upd(5, 1);
      cyc(1, 1, 32'(5 * 4), 0, 0, 0, 0);
      chk("t5_drop", pred_valid, 1'b0);

      // 6: traffic during INIT is ignored
      repeat (3) cyc(0, 1, 32'(7 * 4), 0, 1, 7, 1);
      chk("t6_novalid", pred_valid, 1'b0);
      idle(61);
      chk("t6_ready", ready, 1'b1);
      look(5);
      chk("t5_cleared", pred_taken, 1'b0);
      look(7);
      chk("t6_cleared", pred_taken, 1'b0);

      // Random traffic with occasional resets
      for (int k = 0; k < 600; k++) begin
         r  = ($urandom_range(0, 249) == 0);
         le = $urandom_range(0, 1) == 1;
         pc = $urandom;
         g  = GW'($urandom);
         ue = $urandom_range(0, 1) == 1;
         ut = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 2) == 0) ui = hash(longint'(pc), int'(g));
         else ui = $urandom_range(0, N - 1);
         cyc(r, le, pc, g, ue, ui, ut);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
